cic_interp_mc: RTL and testbench

Multi-channel, parametrised CIC interpolator for the transmit path. It sits between the host-side sample FIFO and the DUC/CORDIC stage. It generates its own input-request strobe from `strobe_out` and the runtime `rate`. It processes `NCH` parallel channels with shared control, and produces each output with round-half-up normalisation, saturation and a sticky overflow flag.

---
 rtl/cic_pkg.sv | 41 ++++
 rtl/cic_interp_chan.sv | 99 +++++++++
 rtl/cic_interp_mc.sv | 105 ++++++++++
 tb/tb_cic_interp_mc.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and helpers for the multi-channel CIC interpolator.
package cic_pkg;

  function automatic int cic_width(input int bw, input int n, input int log2_max_rate);
    return bw + n * log2_max_rate;
  endfunction

  function automatic logic [3:0] floor_log2(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Number of top bits of the shifted result that must agree for it to fit in bw bits.
  function automatic int sat_guard_bits(input int w, input int bw);
    return w - bw + 1;
  endfunction

  // floor(log2(r^(n-1))): r^(n-1) lies in [2^((n-1)*lg), 2^((n-1)*(lg+1))), so only n-2 extra bits need testing.
  function automatic logic [5:0] gain_shift(input logic [8:0] r, input int n);
    logic [63:0] prod;
    int          lg;
    int          base;
    int          s;
    prod = 64'd1;
    for (int i = 0; i < 8; i++) begin
      if (i < n - 1) prod = prod * {55'd0, r};
    end
    lg   = r[8] ? 8 : int'(floor_log2(r[7:0]));
    base = (n - 1) * lg;
    s    = base;
    for (int k = 1; k < 8; k++) begin
      if ((k < n - 1) && ((prod >> (base + k)) != 64'd0)) s = base + k;
    end
    return 6'(s);
  endfunction

endpackage

// File: rtl/cic_interp_chan.sv
// One channel of the CIC interpolator: comb chain, zero-stuffing integrators,
// round-half-up normalisation and saturation to the sample width.
module cic_interp_chan import cic_pkg::*; #(
  parameter int BW = 16,
  parameter int N  = 4,
  parameter int W  = 44
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          adv_i,
  input  logic          in_ready_i,
  input  logic [5:0]    shift_i,
  input  logic [BW-1:0] x_i,
  output logic [BW-1:0] y_o,
  output logic          sat_o
);

  localparam int G = sat_guard_bits(W, BW);

  logic signed [W-1:0] c_q  [N];
  logic signed [W-1:0] c_d  [N];
  logic signed [W-1:0] cd_q [N];
  logic signed [W-1:0] cd_d [N];
  logic signed [W-1:0] g_q  [N];
  logic signed [W-1:0] g_d  [N];
  logic [BW-1:0]       y_q, y_d;

  logic signed [W-1:0] x_ext_s, rnd_s, sum_s, sh_s;
  logic [G-1:0]        guard_s;
  logic                sat_s;
  logic [BW-1:0]       y_sat_s;

  always_comb begin
    x_ext_s = {{(W-BW){x_i[BW-1]}}, x_i};
    rnd_s   = (shift_i == 6'd0) ? '0 : ({{(W-1){1'b0}}, 1'b1} << (shift_i - 6'd1));
    sum_s   = g_q[N-1] + rnd_s;
    sh_s    = sum_s >>> shift_i;
    guard_s = sh_s[W-1 -: G];
    sat_s   = !((&guard_s) || !(|guard_s));
    if (sat_s) begin
      y_sat_s = sh_s[W-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
    end else begin
      y_sat_s = sh_s[BW-1:0];
    end
  end

  assign sat_o = adv_i & sat_s;
  assign y_o   = y_q;

  always_comb begin
    c_d  = c_q;
    cd_d = cd_q;
    g_d  = g_q;
    y_d  = y_q;
    if (!enable) begin
      for (int i = 0; i < N; i++) begin
        c_d[i]  = '0;
        cd_d[i] = '0;
        g_d[i]  = '0;
      end
      y_d = '0;
    end else begin
      if (in_ready_i) begin
        c_d[0]  = x_ext_s - cd_q[0];
        cd_d[0] = x_ext_s;
        for (int i = 1; i < N; i++) begin
          c_d[i]  = c_q[i-1] - cd_q[i];
          cd_d[i] = c_q[i-1];
        end
      end
      // Integrators run at the output rate; the comb output enters only on in_ready cycles.
      if (adv_i) begin
        g_d[0] = g_q[0] + (in_ready_i ? c_q[N-1] : '0);
        for (int j = 1; j < N; j++) begin
          g_d[j] = g_q[j] + g_q[j-1];
        end
        y_d = y_sat_s;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        c_q[i]  <= '0;
        cd_q[i] <= '0;
        g_q[i]  <= '0;
      end
      y_q <= '0;
    end else begin
      c_q  <= c_d;
      cd_q <= cd_d;
      g_q  <= g_d;
      y_q  <= y_d;
    end
  end

endmodule

// File: rtl/cic_interp_mc.sv
// Multi-channel CIC interpolator: shared phase counter and rate/shift control,
// per-channel datapaths, sticky overflow.
module cic_interp_mc import cic_pkg::*; #(
  parameter int BW            = 16,
  parameter int N             = 4,
  parameter int LOG2_MAX_RATE = 7,
  parameter int NCH           = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [7:0]        rate,
  input  logic              strobe_out,
  input  logic [NCH*BW-1:0] signal_in,
  output logic              in_ready,
  output logic [NCH*BW-1:0] signal_out,
  output logic              out_valid,
  output logic              overflow
);

  localparam int         W    = cic_width(BW, N, LOG2_MAX_RATE);
  localparam logic [8:0] RMAX = 9'(2 ** LOG2_MAX_RATE);

  logic [8:0] r_q, r_d, p_q, p_d;
  logic [5:0] s_q, s_d;
  logic       en_q, out_valid_q, overflow_q, overflow_d;
  logic [8:0] r_new_s, r_cur_s;
  logic       adv_s, in_ready_s, latch_s;
  logic [NCH-1:0] sat_s;

  assign adv_s      = enable & strobe_out;
  assign in_ready_s = adv_s & (p_q == 9'd0);
  assign latch_s    = in_ready_s | (enable & ~en_q);

  always_comb begin
    if (rate == 8'd0) begin
      r_new_s = 9'd1;
    end else if ({1'b0, rate} > RMAX) begin
      r_new_s = RMAX;
    end else begin
      r_new_s = {1'b0, rate};
    end
    r_cur_s = latch_s ? r_new_s : r_q;
  end

  always_comb begin
    r_d = r_q;
    s_d = s_q;
    p_d = p_q;
    if (!enable) begin
      p_d = 9'd0;
    end else begin
      if (latch_s) begin
        r_d = r_new_s;
        s_d = gain_shift(r_new_s, N);
      end
      // A rate picked up at p==0 already governs the wrap of the period it starts.
      if (adv_s) begin
        p_d = (p_q + 9'd1 >= r_cur_s) ? 9'd0 : p_q + 9'd1;
      end
    end
    overflow_d = overflow_q | (|sat_s);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q         <= 9'd1;
      s_q         <= 6'd0;
      p_q         <= 9'd0;
      en_q        <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      r_q         <= r_d;
      s_q         <= s_d;
      p_q         <= p_d;
      en_q        <= enable;
      out_valid_q <= adv_s;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    cic_interp_chan #(
      .BW(BW),
      .N (N),
      .W (W)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .adv_i     (adv_s),
      .in_ready_i(in_ready_s),
      .shift_i   (s_q),
      .x_i       (signal_in[c*BW +: BW]),
      .y_o       (signal_out[c*BW +: BW]),
      .sat_o     (sat_s[c])
    );
  end

endmodule

// File: tb/tb_cic_interp_mc.sv
// Scoreboard bench for cic_interp_mc: each enabled strobe queues its expected
// output; a negedge monitor pops and compares whenever out_valid is seen.
module tb_cic_interp_mc;

  localparam int BW = 16, N = 4, LMR = 7, NCH = 2;

  logic              clock = 1'b0;
  logic              reset, enable, strobe_out;
  logic [7:0]        rate;
  logic [NCH*BW-1:0] signal_in, signal_out;
  logic              in_ready, out_valid, overflow;

  always #5 clock = ~clock;

  cic_interp_mc #(.BW(BW), .N(N), .LOG2_MAX_RATE(LMR), .NCH(NCH)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .rate      (rate),
    .strobe_out(strobe_out),
    .signal_in (signal_in),
    .in_ready  (in_ready),
    .signal_out(signal_out),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  typedef struct {
    logic               chk;
    logic signed [15:0] e0;
    logic signed [15:0] e1;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  logic               en_v = 1'b0, rst_v = 1'b1, ir_s;
  logic [7:0]         rate_v = 8'd1;
  logic signed [15:0] x0_v = 16'sd0, x1_v = 16'sd0;

  // CIC impulse response for N=4, R=4: coefficients of (1+z^-1+z^-2+z^-3)^4
  int h[13] = '{1, 4, 10, 20, 31, 40, 44, 40, 31, 20, 10, 4, 1};

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic stb, input logic chk, input int e0, input int e1);
    exp_t e;
    @(negedge clock);
    reset      = rst_v;
    enable     = en_v;
    rate       = rate_v;
    signal_in  = {x1_v, x0_v};
    strobe_out = stb;
    if (stb && en_v && !rst_v) begin
      e.chk = chk;
      e.e0  = 16'(e0);
      e.e1  = 16'(e1);
      sbq.push_back(e);
    end
    #3;
    ir_s = in_ready;
  endtask

  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: out_valid=1 with no pending strobe, want 0");
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.chk) begin
          check("out_ch0", $signed(signal_out[15:0]), mon_e.e0);
          check("out_ch1", $signed(signal_out[31:16]), mon_e.e1);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; strobe_out = 1'b0; rate = 8'd1; signal_in = '0;
    repeat (3) step(1'b0, 1'b0, 0, 0);
    rst_v = 1'b0;
    step(1'b0, 1'b0, 0, 0);
    check("rst_sig", signal_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready", ir_s, 0);

    // R=4 DC: unity gain, in_ready period 4
    rate_v = 8'd4; x0_v = 16'sd1000; x1_v = -16'sd1000; en_v = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step(1'b1, k >= 32, 1000, -1000);
      check("ir_r4", ir_s, (k % 4) == 0);
    end
    check("ovf_dc", overflow, 0);

    // R=4 impulse of 64 on ch0: output is the impulse response starting 20 strobes later
    en_v = 1'b0;
    repeat (2) step(1'b1, 1'b0, 0, 0);
    x0_v = 16'sd64; x1_v = 16'sd0; en_v = 1'b1;
    step(1'b1, 1'b1, 0, 0);
    x0_v = 16'sd0;
    for (int k = 1; k < 40; k++) begin
      step(1'b1, 1'b1, (k >= 20 && k <= 32) ? h[k-20] : 0, 0);
    end

    // R=3 DC: gain 27/16 with round half-up, then saturation and sticky overflow
    en_v = 1'b0;
    repeat (2) step(1'b1, 1'b0, 0, 0);
    rate_v = 8'd3; x0_v = 16'sd1000; x1_v = -16'sd1000; en_v = 1'b1;
    for (int k = 0; k < 56; k++) step(1'b1, k >= 40, 1688, -1687);
    check("ovf_r3", overflow, 0);
    x0_v = 16'sd30000; x1_v = -16'sd30000;
    for (int k = 0; k < 48; k++) step(1'b1, k >= 40, 32767, -32768);
    check("ovf_set", overflow, 1);
    x0_v = 16'sd0; x1_v = 16'sd0;
    for (int k = 0; k < 48; k++) step(1'b1, k >= 40, 0, 0);
    check("ovf_sticky", overflow, 1);

    // Enable dropped for 3 clocks mid-stream
    rate_v = 8'd4; x0_v = 16'sd1000; x1_v = -16'sd1000;
    for (int k = 0; k < 60; k++) step(1'b1, k >= 52, 1000, -1000);
    en_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 0, 0);
      check("ir_dis", ir_s, 0);
      if (k > 0) begin
        check("sig_dis", signal_out, 0);
        check("valid_dis", out_valid, 0);
      end
    end
    check("ovf_hold", overflow, 1);
    en_v = 1'b1;
    step(1'b1, 1'b0, 0, 0);
    check("ir_reen", ir_s, 1);
    check("sig_reen", signal_out, 0);
    for (int k = 1; k < 12; k++) begin
      step(1'b1, 1'b0, 0, 0);
      check("ir_reen_per", ir_s, (k % 4) == 0);
    end

    // Rate 4 -> 8 mid-period, then 8 -> 0 mid-period
    en_v = 1'b0;
    repeat (2) step(1'b1, 1'b0, 0, 0);
    rate_v = 8'd4; en_v = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 1) rate_v = 8'd8;
      if (k == 21) rate_v = 8'd0;
      step(1'b1, 1'b0, 0, 0);
      check("ir_rate", ir_s, (k == 0) || (k == 4) || (k == 12) || (k == 20) || (k >= 28));
    end

    // Reset while saturating clears everything including overflow
    rate_v = 8'd3; x0_v = 16'sd30000; x1_v = -16'sd30000;
    for (int k = 0; k < 60; k++) step(1'b1, k >= 48, 32767, -32768);
    check("ovf_pre_rst", overflow, 1);
    rst_v = 1'b1;
    step(1'b1, 1'b0, 0, 0);
    rst_v = 1'b0; en_v = 1'b0;
    step(1'b0, 1'b0, 0, 0);
    check("sig_rst", signal_out, 0);
    check("ovf_rst", overflow, 0);
    check("valid_rst", out_valid, 0);

    repeat (3) step(1'b0, 1'b0, 0, 0);
    check("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
